display_scanner: RTL and testbench

Time-multiplexed driver for the board's four-digit seven-segment display, directly downstream of the memory controller. Captures the 16-bit word the controller presents with `ready`, holds it in a shadow register, and commits it to the display register only at a frame boundary so a frame never shows mixed old and new digits. Generates its own refresh timing from the system clock, and drives registered active-low anode and segment lines.

---
 rtl/display_pkg.sv | 34 +++
 rtl/display_scanner_prescaler.sv | 28 ++
 rtl/display_scanner.sv | 121 ++++++++++++
 tb/tb_display_scanner.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and seven-segment encoding for the display scanner.
package display_pkg;

  localparam int          DIGIT_COUNT = 4;
  localparam int          INDEX_W     = $clog2(DIGIT_COUNT);
  localparam logic [3:0]  ANODE_OFF   = 4'hF;
  localparam logic [6:0]  SEG_OFF     = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display_scanner_prescaler.sv
// Digit-slot prescaler: counts 0..REFRESH_DIVISOR-1 and flags the terminal count.
module refresh_prescaler #(
  parameter int REFRESH_DIVISOR = 100000
) (
  input  logic clock,
  input  logic reset_n,
  output logic slot_end
);

  localparam int             CNT_W    = $clog2(REFRESH_DIVISOR);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(REFRESH_DIVISOR - 1);

  logic [CNT_W-1:0] count_r;

  assign slot_end = (count_r == TERMINAL);

  // Free-running slot counter, wraps to zero after the terminal count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (slot_end) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed seven-segment driver with frame-aligned word commit.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCANNER_BLANK_EN.
module display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIVISOR = 100000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] data,
  input  logic        ready,
  output logic [3:0]  anode,
  output logic [6:0]  segment,
  output logic        frame_tick
);

  logic                   slot_end_s;
  logic                   wrap_s;
  logic [INDEX_W-1:0]     index_r;
  logic [15:0]            shadow_r;
  logic [15:0]            display_r;
  logic                   pending_r;
  logic                   wrap_d_r;
  logic [3:0]             nibble_s;
  logic [DIGIT_COUNT-1:0] blank_s;
  logic [3:0]             anode_next_s;
  logic [6:0]             segment_next_s;

  refresh_prescaler #(
    .REFRESH_DIVISOR(REFRESH_DIVISOR)
  ) u_prescaler (
    .clock    (clock),
    .reset_n  (reset_n),
    .slot_end (slot_end_s)
  );

  assign wrap_s = slot_end_s && (index_r == INDEX_W'(DIGIT_COUNT - 1));

  // Digit index advances once per slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      index_r <= '0;
    end else if (slot_end_s) begin
      index_r <= index_r + INDEX_W'(1);
    end else begin
      index_r <= index_r;
    end
  end

  // Shadow capture and frame-boundary commit; a word arriving on the wrap bypasses the shadow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_r  <= 16'h0000;
      display_r <= 16'h0000;
      pending_r <= 1'b0;
    end else begin
      if (ready) begin
        shadow_r <= data;
      end else begin
        shadow_r <= shadow_r;
      end
      if (wrap_s) begin
        pending_r <= 1'b0;
        if (ready) begin
          display_r <= data;
        end else if (pending_r) begin
          display_r <= shadow_r;
        end else begin
          display_r <= display_r;
        end
      end else begin
        display_r <= display_r;
        pending_r <= ready ? 1'b1 : pending_r;
      end
    end
  end

  // Select the nibble for the current slot and decide whether it is blanked.
  always_comb begin
    nibble_s = 4'h0;
    blank_s  = '0;
    case (index_r)
      2'd0:    nibble_s = display_r[3:0];
      2'd1:    nibble_s = display_r[7:4];
      2'd2:    nibble_s = display_r[11:8];
      2'd3:    nibble_s = display_r[15:12];
      default: nibble_s = 4'h0;
    endcase
`ifdef DISPLAY_SCANNER_BLANK_EN
    blank_s[3] = (display_r[15:12] == 4'h0);
    blank_s[2] = blank_s[3] && (display_r[11:8] == 4'h0);
    blank_s[1] = blank_s[2] && (display_r[7:4] == 4'h0);
    blank_s[0] = 1'b0;
`else
    blank_s = '0;
`endif
    if (blank_s[index_r]) begin
      anode_next_s   = ANODE_OFF;
      segment_next_s = SEG_OFF;
    end else begin
      anode_next_s   = ANODE_OFF & ~(4'b0001 << index_r);
      segment_next_s = hex_to_seg(nibble_s);
    end
  end

  // Registered pad drivers; frame_tick is delayed to line up with the index-0 anode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      anode      <= ANODE_OFF;
      segment    <= SEG_OFF;
      wrap_d_r   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      anode      <= anode_next_s;
      segment    <= segment_next_s;
      wrap_d_r   <= wrap_s;
      frame_tick <= wrap_d_r;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner with REFRESH_DIVISOR = 4.
module tb_display_scanner;

  logic        clock;
  logic        reset_n;
  logic [15:0] data;
  logic        ready;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        frame_tick;

  int vectors;
  int miscompares;
  int e;

  display_scanner #(.REFRESH_DIVISOR(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .data       (data),
    .ready      (ready),
    .anode      (anode),
    .segment    (segment),
    .frame_tick (frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    e = e + 1;
  endtask

  task automatic run_to(input int target);
    while (e < target) tick();
  endtask

  // e counts rising edges since reset release; frame_tick is due on edges 17, 33, ...
  task automatic chk(input string tag, input logic [3:0] a_exp, input logic [6:0] s_exp);
    logic ft_exp;
    ft_exp = (e > 1) && ((e % 16) == 1);
    vectors = vectors + 1;
    assert (anode === a_exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s e=%0d anode observed %b expected %b", tag, e, anode, a_exp);
    end
    vectors = vectors + 1;
    assert (segment === s_exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s e=%0d segment observed %h expected %h", tag, e, segment, s_exp);
    end
    vectors = vectors + 1;
    assert (frame_tick === ft_exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s e=%0d frame_tick observed %b expected %b", tag, e, frame_tick, ft_exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    vectors = vectors + 1;
    assert (anode === 4'b1111 && segment === 7'h7F && frame_tick === 1'b0) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed %b/%h/%b expected 1111/7f/0", tag, anode, segment, frame_tick);
    end
  endtask

  task automatic send(input int at_edge, input logic [15:0] word);
    run_to(at_edge - 1);
    data  = word;
    ready = 1'b1;
    run_to(at_edge);
    ready = 1'b0;
    data  = 16'h0000;
  endtask

  initial begin
    logic [3:0] a_exp;
    int idx;
    vectors     = 0;
    miscompares = 0;
    e           = 0;
    reset_n     = 1'b0;
    data        = 16'h0000;
    ready       = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    chk_reset("reset_hold");
    @(negedge clock);
    reset_n = 1'b1;

    // Idle scan: anode walks every 4 edges, digits all "0".
    for (int k = 1; k <= 32; k++) begin
      tick();
      idx   = ((e - 1) / 4) % 4;
      a_exp = 4'b1111 & ~(4'b0001 << idx);
      chk("idle_scan", a_exp, 7'h40);
    end

    // Mid-frame word waits for the wrap at edge 48.
    send(37, 16'h1A3F);
    run_to(40); chk("hold_before_wrap", 4'b1101, 7'h40);
    run_to(48); chk("wrap_edge_old",    4'b0111, 7'h40);
    run_to(49); chk("1a3f_d0",          4'b1110, 7'h0E);
    run_to(53); chk("1a3f_d1",          4'b1101, 7'h30);
    run_to(57); chk("1a3f_d2",          4'b1011, 7'h08);
    run_to(61); chk("1a3f_d3",          4'b0111, 7'h79);

    // Pending 1111 overridden by 5555 arriving on the wrap edge 80.
    send(66, 16'h1111);
    send(80, 16'h5555);
    run_to(81); chk("bypass_d0",  4'b1110, 7'h12);
    run_to(85); chk("bypass_d1",  4'b1101, 7'h12);
    run_to(97); chk("bypass_hold", 4'b1110, 7'h12);

    // Two words in one frame: only the last is committed at edge 112.
    send(98, 16'h0001);
    send(100, 16'h0002);
    run_to(113); chk("last_wins_d0", 4'b1110, 7'h24);
    run_to(117); chk("last_wins_d1", 4'b1101, 7'h40);

    // Asynchronous reset discards a pending word.
    send(114, 16'hFFFF);
    run_to(120);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("async_reset");
    @(posedge clock);
    #1;
    chk_reset("reset_low_edge");
    @(negedge clock);
    reset_n = 1'b1;
    e = 0;
    run_to(1);  chk("post_reset_first", 4'b1110, 7'h40);
    run_to(16); chk("post_reset_d3",    4'b0111, 7'h40);
    run_to(17); chk("post_reset_wrap",  4'b1110, 7'h40);

    // Leading-zero blanking on 0070.
    send(18, 16'h0070);
    run_to(33); chk("w0070_d0", 4'b1110, 7'h40);
    run_to(37); chk("w0070_d1", 4'b1101, 7'h78);
`ifdef DISPLAY_SCANNER_BLANK_EN
    run_to(41); chk("w0070_d2_blank", 4'b1111, 7'h7F);
    run_to(45); chk("w0070_d3_blank", 4'b1111, 7'h7F);
`else
    run_to(41); chk("w0070_d2", 4'b1011, 7'h40);
    run_to(45); chk("w0070_d3", 4'b0111, 7'h40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
